alu_issue: RTL
==============

Name: alu_issue

Overview:
- Issue/writeback sequencer sitting directly upstream and downstream of the CPU's R-type ALU.
- Accepts one decoded R-type instruction word plus its register operand values (rs_val, rt_val) over a valid/ready handshake.
- Drives the ALU's a/b/shamt/funct inputs and a single-cycle go pulse, since the ALU evaluates on the rising edge of go.
- Captures the ALU result and presents it to register writeback over a second valid/ready handshake, with destination register and write enable.

Parameters:
- DATA_W, 32: operand and result width; must match the ALU.
- SETTLE, 1: extra clk cycles, 0..7, inserted after the go pulse before alu_out is sampled.

Ports:
- clk  input  1  system clock; all state on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  block can accept; high only in IDLE.
- instr  input  32  instruction word. Fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
- rs_val  input  DATA_W  value of register rs.
- rt_val  input  DATA_W  value of register rt.
- alu_a  output  DATA_W  to ALU a.
- alu_b  output  DATA_W  to ALU b.
- alu_shamt  output  5  to ALU shamt.
- alu_funct  output  6  to ALU funct.
- alu_go  output  1  to ALU go; registered, one-cycle pulse.
- alu_out  input  DATA_W  from ALU out.
- wb_valid  output  1  result available.
- wb_ready  input  1  writeback accepts.
- wb_rd  output  5  destination register.
- wb_data  output  DATA_W  captured result.
- wb_we  output  1  register write enable.
- illegal  output  1  instruction not supported; qualified by wb_valid.

Behaviour:
- Reset: clk and reset are the only clock/reset; reset is synchronous, active-high.
  - State goes to IDLE.
  - All of the following are 0: alu_a, alu_b, alu_shamt, alu_funct, alu_go, wb_valid, wb_rd, wb_data, wb_we, illegal.
  - in_ready is 1 in the cycle after reset deasserts.
- Reset mid-operation wins over every other event, including a GO or RESP state. Any in-flight instruction is dropped with no response. alu_go is 0 on the next edge. ALU hi/lo may already have been updated; that is permitted.
- FSM states: IDLE, SETUP, GO, WAIT, CAPT, RESP.
- IDLE: in_ready=1. On in_valid&&in_ready, latch operands and decode:
  - Supported: op==0 and funct in {00,02,10,12,18,1A,20,22,24,25,26,27,2A}.
    - Shift (funct 00, 02): alu_a=rt_val, alu_b=0.
    - All other supported functs: alu_a=rs_val, alu_b=rt_val.
    - alu_shamt=shamt, alu_funct=funct.
    - Go to SETUP.
  - Otherwise illegal: latch illegal=1, wb_data=0, wb_we=0, wb_rd=rd. Go directly to RESP with no go pulse.
- SETUP: ALU inputs stable, alu_go=0. Next state GO.
- GO: alu_go=1 for exactly this cycle.
  - Next state WAIT if SETTLE>0, else CAPT.
- WAIT: counts SETTLE cycles with alu_go=0, then goes to CAPT.
- CAPT: alu_go=0.
  - wb_data<=alu_out, wb_rd<=rd.
  - wb_we<=1 only if funct is not 18 or 1A and rd!=0.
  - For mult/div, wb_we=0 and wb_data is don't-care-captured.
  - Next state RESP.
- RESP: wb_valid=1. wb_rd, wb_data, wb_we and illegal are held stable until wb_valid&&wb_ready.
  - On transfer, go to IDLE, clearing wb_valid and illegal.
  - in_ready rises the following cycle; there is no same-cycle re-accept.
- Latency, accept edge to wb_valid high: 4+SETTLE cycles for supported instructions, 1 cycle for illegal. Throughput is one instruction per 5+SETTLE cycles minimum.
- ALU inputs hold their last values outside SETUP..CAPT and are never changed while alu_go=1 or in WAIT.
- rd==0: the ALU still executes (mfhi/mflo semantics preserved) but wb_we=0.
- in_valid while not in IDLE is ignored; upstream must hold it.
- wb_ready held low: stay in RESP indefinitely; no further go pulses.

Test Plan:
- add $3,$1,$2 (instr 0x00221820, rs_val=5, rt_val=7, SETTLE=1, wb_ready=1) -> exactly one alu_go pulse 2 cycles after accept; wb_valid 5 cycles after accept with wb_rd=3, wb_data=12, wb_we=1, illegal=0.
- sll $4,$2,3 (instr 0x000220C0, rt_val=0x1, rs_val=0xFFFF) -> alu_a=0x1, alu_shamt=3; wb_data=0x8, wb_rd=4, wb_we=1.
- mult (funct 18, rs_val=3, rt_val=4), then mflo $5 (funct 12) -> first response wb_we=0; second response wb_data=12, wb_rd=5, wb_we=1.
- op=0x23 or funct=0x3F -> no alu_go pulse; wb_valid 1 cycle after accept with illegal=1, wb_we=0, wb_data=0.
- Back-pressure: wb_ready=0 for 10 cycles in RESP -> wb_* stable, in_ready=0, alu_go=0 throughout; wb_ready=1 -> single transfer, in_ready=1 next cycle.
- Reset asserted in the GO cycle -> next edge alu_go=0, wb_valid=0, all outputs 0, in_ready=1 after release; no response ever issued for the dropped instruction.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: issue/writeback sequencer wrapped around the R-type ALU.
// Latches one decoded R-type instruction and its operands, and drives the ALU
// inputs. It fires a one-cycle go pulse, waits SETTLE cycles and captures the
// ALU result. It then offers the result to register writeback over valid/ready.
module alu_issue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_shamt,
  output logic [5:0]        alu_funct,
  output logic              alu_go,
  input  logic [DATA_W-1:0] alu_out,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic              illegal
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_GO, S_WAIT, S_CAPT, S_RESP
  } state_e;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } rtype_t;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         rd_q, rd_d;

  logic               in_ready_q, in_ready_d;
  logic [DATA_W-1:0]  alu_a_q, alu_a_d;
  logic [DATA_W-1:0]  alu_b_q, alu_b_d;
  logic [4:0]         alu_shamt_q, alu_shamt_d;
  logic [5:0]         alu_funct_q, alu_funct_d;
  logic               alu_go_q, alu_go_d;
  logic               wb_valid_q, wb_valid_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]  wb_data_q, wb_data_d;
  logic               wb_we_q, wb_we_d;
  logic               illegal_q, illegal_d;

  rtype_t ins;
  logic   funct_ok_c;
  logic   legal_c;
  logic   shift_c;
  logic   accept_c;
  logic   no_wb_funct_c;
  logic   unused_fields;

  assign ins           = rtype_t'(instr);
  assign unused_fields = ^{ins.rs, ins.rt};
  assign legal_c       = (ins.op == 6'h00) && funct_ok_c;
  assign shift_c       = (ins.funct == 6'h00) || (ins.funct == 6'h02);
  assign accept_c      = (state_q == S_IDLE) && in_valid && in_ready_q;
  assign no_wb_funct_c = (alu_funct_q == 6'h18) || (alu_funct_q == 6'h1A);

  // Supported R-type function codes.
  always_comb begin
    funct_ok_c = 1'b0;
    case (ins.funct)
      6'h00, 6'h02, 6'h10, 6'h12, 6'h18, 6'h1A, 6'h20,
      6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A: funct_ok_c = 1'b1;
      default:                                  funct_ok_c = 1'b0;
    endcase
  end

  // State and settle-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  // Next-state logic; illegal instructions skip straight to the response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) state_d = legal_c ? S_SETUP : S_RESP;
      end
      S_SETUP: state_d = S_GO;
      S_GO: begin
        if (SETTLE > 0) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(SETTLE - 1);
        end else begin
          state_d = S_CAPT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_CAPT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_CAPT: state_d = S_RESP;
      S_RESP: begin
        if (wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output next values; strobes track the state being entered so they line up with it.
  always_comb begin
    in_ready_d  = (state_d == S_IDLE);
    alu_go_d    = (state_d == S_GO);
    wb_valid_d  = (state_d == S_RESP);
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_shamt_d = alu_shamt_q;
    alu_funct_d = alu_funct_q;
    rd_d        = rd_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_we_d     = wb_we_q;
    illegal_d   = illegal_q;

    if (accept_c) begin
      if (legal_c) begin
        alu_a_d     = shift_c ? rt_val : rs_val;
        alu_b_d     = shift_c ? '0 : rt_val;
        alu_shamt_d = ins.shamt;
        alu_funct_d = ins.funct;
        rd_d        = ins.rd;
      end else begin
        illegal_d = 1'b1;
        wb_data_d = '0;
        wb_we_d   = 1'b0;
        wb_rd_d   = ins.rd;
      end
    end

    if (state_q == S_CAPT) begin
      wb_data_d = alu_out;
      wb_rd_d   = rd_q;
      wb_we_d   = !no_wb_funct_c && (rd_q != 5'd0);
    end

    if ((state_q == S_RESP) && wb_ready) illegal_d = 1'b0;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_q  <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_shamt_q <= '0;
      alu_funct_q <= '0;
      alu_go_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      wb_we_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_shamt_q <= alu_shamt_d;
      alu_funct_q <= alu_funct_d;
      alu_go_q    <= alu_go_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_we_q     <= wb_we_d;
      illegal_q   <= illegal_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_shamt = alu_shamt_q;
  assign alu_funct = alu_funct_q;
  assign alu_go    = alu_go_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign wb_we     = wb_we_q;
  assign illegal   = illegal_q;

endmodule
